// File: rtl/maxpool_win.sv
// Serial-input windowed signed maxpool: deserialises NO_CH channels, slides a POOL/STRIDE window, emits per-channel max.
// Optional MAXPOOL_TAIL_EN: emit a final partial window at sequence end when the last element does not trigger one.
module maxpool_win #(
    parameter int NO_CH  = 10,
    parameter int BW_IN  = 12,
    parameter int SER_BW = 4,
    parameter int POOL   = 2,
    parameter int STRIDE = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_in,
    input  logic                          last_in,
    input  logic [NO_CH-1:0][SER_BW-1:0]  data_in,
    output logic                          vld_out,
    output logic                          last_out,
    output logic [NO_CH-1:0][BW_IN-1:0]   data_out
);

    localparam int WORD_CYC = BW_IN / SER_BW;
    localparam int WCW      = (WORD_CYC > 1) ? $clog2(WORD_CYC) : 1;
    localparam int FW       = $clog2(POOL + 1);
    localparam int PW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [WCW-1:0] WC_LAST = WCW'(WORD_CYC - 1);
    localparam logic [FW-1:0]  POOL_F  = FW'(POOL);
    localparam logic [PW-1:0]  PH_LAST = PW'(STRIDE - 1);

    logic [WCW-1:0]                        wcnt_q, wcnt_d;
    logic [NO_CH-1:0][BW_IN-1:0]           asm_q, asm_d;
    logic [POOL-1:0][NO_CH-1:0][BW_IN-1:0] win_q, win_d;
    logic [FW-1:0]                         fill_q, fill_d;
    logic [PW-1:0]                         phase_q, phase_d;
    logic [FW-1:0]                         wn_q, wn_d;
    logic                                  pend_q, pend_d;
    logic                                  pend_last_q, pend_last_d;
    logic                                  vld_out_q, vld_out_d;
    logic                                  last_out_q, last_out_d;
    logic [NO_CH-1:0][BW_IN-1:0]           data_out_q, data_out_d;

    logic                                  final_beat;
    logic [NO_CH-1:0][BW_IN-1:0]           elem;
    logic [FW-1:0]                         new_fill;
    logic [PW-1:0]                         ph_cur;
    logic                                  trig;
    logic [NO_CH-1:0][BW_IN-1:0]           mx;

    // Window max: entries at index >= wn_q are stale and are masked out.
    always_comb begin
        mx = '0;
        for (int unsigned c = 0; c < NO_CH; c++) begin
            mx[c] = win_q[0][c];
            for (int unsigned i = 1; i < POOL; i++) begin
                if (FW'(i) < wn_q && $signed(win_q[i][c]) > $signed(mx[c]))
                    mx[c] = win_q[i][c];
            end
        end
    end

    always_comb begin
        wcnt_d      = wcnt_q;
        asm_d       = asm_q;
        win_d       = win_q;
        fill_d      = fill_q;
        phase_d     = phase_q;
        wn_d        = wn_q;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;

        final_beat = vld_in && (wcnt_q == WC_LAST);
        elem = asm_q;
        for (int unsigned c = 0; c < NO_CH; c++)
            elem[c][wcnt_q*SER_BW +: SER_BW] = data_in[c];

        new_fill = (fill_q == POOL_F) ? POOL_F : fill_q + FW'(1);
        ph_cur   = (fill_q == POOL_F) ? phase_q : '0;
        trig     = (new_fill == POOL_F) && (ph_cur == '0);

        if (vld_in) begin
            asm_d  = elem;
            wcnt_d = final_beat ? '0 : wcnt_q + WCW'(1);
        end

        if (final_beat) begin
            win_d[0] = elem;
            for (int unsigned i = 1; i < POOL; i++)
                win_d[i] = win_q[i-1];
            fill_d      = new_fill;
            phase_d     = (ph_cur == PH_LAST) ? '0 : ph_cur + PW'(1);
            wn_d        = new_fill;
            pend_d      = trig;
            pend_last_d = trig && last_in;
`ifdef MAXPOOL_TAIL_EN
            if (last_in && !trig) begin
                pend_d      = 1'b1;
                pend_last_d = 1'b1;
            end
`endif
            // Window contents survive the sequence end: the max stage still reads them next cycle.
            if (last_in) begin
                fill_d  = '0;
                phase_d = '0;
            end
        end

        vld_out_d  = pend_q;
        last_out_d = pend_last_q;
        data_out_d = pend_q ? mx : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            asm_q       <= '0;
            win_q       <= '0;
            fill_q      <= '0;
            phase_q     <= '0;
            wn_q        <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            vld_out_q   <= 1'b0;
            last_out_q  <= 1'b0;
            data_out_q  <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            asm_q       <= asm_d;
            win_q       <= win_d;
            fill_q      <= fill_d;
            phase_q     <= phase_d;
            wn_q        <= wn_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            vld_out_q   <= vld_out_d;
            last_out_q  <= last_out_d;
            data_out_q  <= data_out_d;
        end
    end

    assign vld_out  = vld_out_q;
    assign last_out = last_out_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_maxpool_win.sv
// Bench for maxpool_win: two instances (POOL=2/STRIDE=2 and POOL=3/STRIDE=1) share one serial stream,
// each checked against a sequence-level reference model.
module tb_maxpool_win;

    localparam int WC = 3;

    logic             clk = 1'b0;
    logic             rst, vld_in, last_in;
    logic [1:0][3:0]  data_in;
    logic             va, la, vb, lb;
    logic [1:0][11:0] da, db;

    always #5 clk = ~clk;

    maxpool_win #(.NO_CH(2), .BW_IN(12), .SER_BW(4), .POOL(2), .STRIDE(2)) dut_a (
        .clk(clk), .rst(rst), .vld_in(vld_in), .last_in(last_in), .data_in(data_in),
        .vld_out(va), .last_out(la), .data_out(da));

    maxpool_win #(.NO_CH(2), .BW_IN(12), .SER_BW(4), .POOL(3), .STRIDE(1)) dut_b (
        .clk(clk), .rst(rst), .vld_in(vld_in), .last_in(last_in), .data_in(data_in),
        .vld_out(vb), .last_out(lb), .data_out(db));

    typedef struct {
        int          due;
        bit          last;
        logic [11:0] d0;
        logic [11:0] d1;
    } exp_t;

    exp_t        qa[$], qb[$];
    int          hist0[$], hist1[$];
    logic [3:0]  pw0[$], pw1[$];
    int          nel;
    int          cyc = 0;
    int          n_vec = 0, n_err = 0;
    bit          mon_en = 0;
    bit          due_a, due_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int sx(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    function automatic int wmax(input int h[$], input int k);
        int m = h[h.size()-1];
        for (int i = 1; i < k; i++)
            if (h[h.size()-1-i] > m) m = h[h.size()-1-i];
        return m;
    endfunction

    // Element n (1-based) closes a window when n >= P and (n-P) is a multiple of S.
    function automatic bit predict(input int p, input int s, input bit l, output exp_t e);
        bit trig = (nel >= p) && (((nel - p) % s) == 0);
        bit tail = 1'b0;
        int k = (nel < p) ? nel : p;
`ifdef MAXPOOL_TAIL_EN
        tail = l && !trig;
`endif
        e.due  = cyc + 2;
        e.last = l;
        e.d0   = 12'(wmax(hist0, k));
        e.d1   = 12'(wmax(hist1, k));
        return trig || tail;
    endfunction

    function automatic void accept(input bit l, input logic [3:0] w0, input logic [3:0] w1);
        exp_t e;
        int v0 = 0, v1 = 0;
        pw0.push_back(w0);
        pw1.push_back(w1);
        if (pw0.size() == WC) begin
            for (int k = 0; k < WC; k++) begin
                v0 += int'(pw0[k]) << (4 * k);
                v1 += int'(pw1[k]) << (4 * k);
            end
            hist0.push_back(sx(12'(v0)));
            hist1.push_back(sx(12'(v1)));
            nel++;
            if (predict(2, 2, l, e)) qa.push_back(e);
            if (predict(3, 1, l, e)) qb.push_back(e);
            pw0.delete();
            pw1.delete();
            if (l) begin
                hist0.delete();
                hist1.delete();
                nel = 0;
            end
            while (hist0.size() > 3) begin
                void'(hist0.pop_front());
                void'(hist1.pop_front());
            end
        end
    endfunction

    function automatic void flush();
        pw0.delete(); pw1.delete();
        hist0.delete(); hist1.delete();
        nel = 0;
        while (qa.size() > 0 && qa[qa.size()-1].due > cyc) void'(qa.pop_back());
        while (qb.size() > 0 && qb[qb.size()-1].due > cyc) void'(qb.pop_back());
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            due_a = (qa.size() > 0) && (qa[0].due == cyc);
            check("a_vld", 32'(va), 32'(due_a));
            if (due_a) begin
                check("a_d0", 32'(da[0]), 32'(qa[0].d0));
                check("a_d1", 32'(da[1]), 32'(qa[0].d1));
                check("a_last", 32'(la), 32'(qa[0].last));
                void'(qa.pop_front());
            end
            due_b = (qb.size() > 0) && (qb[0].due == cyc);
            check("b_vld", 32'(vb), 32'(due_b));
            if (due_b) begin
                check("b_d0", 32'(db[0]), 32'(qb[0].d0));
                check("b_d1", 32'(db[1]), 32'(qb[0].d1));
                check("b_last", 32'(lb), 32'(qb[0].last));
                void'(qb.pop_front());
            end
        end
    end

    task automatic beat(input bit v, input bit l, input logic [3:0] w0, input logic [3:0] w1);
        @(negedge clk);
        vld_in     = v;
        last_in    = l;
        data_in[0] = w0;
        data_in[1] = w1;
        if (v) accept(l, w0, w1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic send_elem(input logic [11:0] e0, input logic [11:0] e1, input bit l,
                             input int gap, input bit rnd);
        for (int k = 0; k < WC; k++) begin
            beat(1'b1, (k == WC - 1) ? l : (rnd ? 1'($urandom) : 1'b0), e0[4*k +: 4], e1[4*k +: 4]);
            idle(rnd ? int'($urandom_range(0, 2)) : gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        vld_in  = 1'($urandom);
        last_in = 1'b0;
        data_in = 8'($urandom);
        flush();
        @(negedge clk);
        rst    = 1'b0;
        vld_in = 1'b0;
    endtask

    function automatic logic [11:0] rval();
        case ($urandom % 8)
            0:       return 12'h800;
            1:       return 12'h7FF;
            2:       return 12'hFFF;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; vld_in = 1'b0; last_in = 1'b0; data_in = '0; nel = 0;
        repeat (3) @(negedge clk);
        check("rst_va", 32'(va), 32'd0);
        check("rst_la", 32'(la), 32'd0);
        check("rst_da", 32'(da), 32'd0);
        check("rst_vb", 32'(vb), 32'd0);
        check("rst_db", 32'(db), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // basic, most negative, ties
        send_elem(12'h005, 12'h0A0, 1'b0, 0, 1'b0);
        send_elem(12'hFFE, 12'h7FF, 1'b0, 0, 1'b0);
        idle(4);
        do_reset();
        send_elem(12'h800, 12'h800, 1'b0, 0, 1'b0);
        send_elem(12'h801, 12'h800, 1'b0, 0, 1'b0);
        send_elem(12'h123, 12'hF00, 1'b0, 0, 1'b0);
        send_elem(12'h123, 12'h0FF, 1'b0, 0, 1'b0);
        idle(4);

        // overlapping windows, without and with bubbles
        for (int g = 0; g < 2; g++) begin
            do_reset();
            send_elem(12'd1, 12'hFF0, 1'b0, g, 1'b0);
            send_elem(12'd7, 12'hFF1, 1'b0, g, 1'b0);
            send_elem(12'd2, 12'hFF2, 1'b0, g, 1'b0);
            send_elem(12'd3, 12'h800, 1'b0, g, 1'b0);
            send_elem(12'd9, 12'hFF3, 1'b0, g, 1'b0);
            idle(4);
        end

        // framing: last on third element, then a fresh sequence
        do_reset();
        send_elem(12'd1, 12'd10, 1'b0, 0, 1'b0);
        send_elem(12'd4, 12'd20, 1'b0, 0, 1'b0);
        send_elem(12'd6, 12'd30, 1'b1, 0, 1'b0);
        send_elem(12'd2, 12'hFFF, 1'b0, 0, 1'b0);
        send_elem(12'd8, 12'hFFE, 1'b0, 0, 1'b0);
        idle(4);

        // reset mid-element
        do_reset();
        beat(1'b1, 1'b0, 4'hF, 4'hF);
        beat(1'b1, 1'b0, 4'h7, 4'h7);
        do_reset();
        send_elem(12'd3, 12'd1, 1'b0, 0, 1'b0);
        send_elem(12'd5, 12'd0, 1'b0, 0, 1'b0);
        idle(4);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom % 60 == 0) begin
                if ($urandom % 2) beat(1'b1, 1'b0, 4'($urandom), 4'($urandom));
                do_reset();
            end
            send_elem(rval(), rval(), ($urandom % 8) == 0, 0, 1'b1);
        end
        idle(6);
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maxpool_win.md
Name: maxpool_win

Overview:
- Parametrised successor to the 1D serial maxpool. Configurable pool window (POOL) and stride (STRIDE), with overlapping windows allowed, plus per-sequence framing via last_in/last_out.
- Accepts NO_CH channels of serial data, least significant word first, SER_BW bits per beat.
- Rebuilds each BW_IN-bit signed element, then emits the per-channel signed max of each window.
- Sits between serialised conv layer outputs and the next layer's input.

Parameters:
- NO_CH, 10: number of parallel channels.
- BW_IN, 12: signed element width.
- SER_BW, 4: bits per channel per beat. Must divide BW_IN.
- POOL, 2: window length in elements, >= 1.
- STRIDE, 2: elements between successive windows, 1 <= STRIDE <= POOL.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- vld_in  in  1  one serial word per channel valid this cycle.
- last_in  in  1  final element of a sequence. Sampled only on the beat carrying an element's final word.
- data_in  in  [NO_CH-1:0][SER_BW-1:0]  serial words, least significant word first.
- vld_out  out  1  data_out valid (single-cycle pulse per window).
- last_out  out  1  with vld_out: last window of the sequence.
- data_out  out  [NO_CH-1:0][BW_IN-1:0]  per-channel window max, signed.

Behaviour:
- WORD_CYC = BW_IN/SER_BW. Word counter 0..WORD_CYC-1 advances only on vld_in. Beats with vld_in=0 are bubbles and are ignored.
- Deserialiser: word k lands in bits [k*SER_BW +: SER_BW]. The element completes on the beat where the counter equals WORD_CYC-1, at cycle T.
- Window: per channel, a shift register of POOL elements, newest at index 0. It shifts at T+1. The fill counter saturates at POOL.
- Stride phase: cleared when fill first reaches POOL; thereafter increments mod STRIDE per completed element.
- An element triggers a window when, including itself, fill == POOL and phase == 0.
- Max: signed compare tree over the POOL entries, registered.
- Timing: vld_out and data_out appear at cycle T+2. Latency is fixed at 2 cycles from the final-word beat. Throughput is one element per WORD_CYC beats, with no backpressure.
- Ties: equal values give that value. Most negative value (e.g. 0x800 for 12 bits) must compare correctly.
- last_in on a final-word beat ends the sequence after that element. Word counter, fill and phase clear at T+1, so the next beat starts a fresh sequence with no stale window contents.
- last_out=1 together with vld_out if the final element triggers a window.
- last_in on a non-final word is ignored.
- POOL=1, STRIDE=1: data_out equals each element, delayed 2 cycles.
- Reset:
  - vld_out=0, last_out=0, data_out=0.
  - All counters 0, window contents 0.
  - Reset mid-element or mid-window discards the partial data. No output for it.
- Reset asserted in the same cycle as vld_in: reset wins and the beat is dropped.

Optional Feature:
- Macro MAXPOOL_TAIL_EN.
- Defined: if the final element of a sequence does not trigger a window, but at least one element has been accepted since the last emitted window (or since sequence start), emit a tail window at T+2 with vld_out=1 and last_out=1. It is the max over the newest min(fill, POOL) elements. A sequence shorter than POOL therefore still produces one output.
- Undefined: no tail output. Trailing elements are dropped, and last_out is seen only when the final element triggers a window.

Test Plan:
- NO_CH=2, BW_IN=12, SER_BW=4, POOL=2, STRIDE=2. ch0 elements 0x005, 0xFFE (signed -2) sent as words 5,0,0 then E,F,F -> one vld_out 2 cycles after the 6th beat, data_out ch0 = 0x005.
- Same config, ch0 = 0x800, 0x801 -> ch0 = 0x801. Ties 0x123, 0x123 -> 0x123.
- POOL=3, STRIDE=1, ch0 elements 1,7,2,3,9 -> outputs 7,7,9 on elements 3, 4 and 5. No output on elements 1 and 2.
- Bubbles: same stream as case 3 with vld_in=0 inserted between every beat -> identical outputs, each 2 cycles after its final-word beat.
- POOL=2, STRIDE=2, last_in on the 3rd element of 1,4,6:
  - Without the macro: one output 4, last_out=0, and the next sequence starts clean.
  - With MAXPOOL_TAIL_EN: a second output 6 with last_out=1.
- Assert rst after 2 words of an element, then send 2 full elements 3,5 -> a single output 5. No corruption from the partial word.
